// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions.
//   - ALU control-code constants driven by the control unit.
//   - muldiv_state_t: state encoding for the multi-cycle MUL/DIV sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_MUL = 4'd10;
  localparam logic [3:0] ALU_NEG = 4'd11;
  localparam logic [3:0] ALU_NOT = 4'd12;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_PREP,
    MD_RUN,
    MD_FIX,
    MD_DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the MUL/DIV sequencer.
// Ports:
//   is_div    : 1 = restoring divide step, 0 = shift-add multiply step
//   acc       : accumulator (MUL: upper product half, DIV: partial remainder)
//   shreg     : shift register (MUL: multiplier/low product, DIV: dividend/quotient)
//   operand   : unsigned magnitude (MUL: multiplicand, DIV: divisor)
//   acc_nxt   : accumulator after this iteration
//   shreg_nxt : shift register after this iteration
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] shreg,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] shreg_nxt
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // MUL: {acc, shreg} is one 2*WIDTH register; add multiplicand into the
    // upper half when the current multiplier LSB is set, then shift right.
    add_sum = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
    // DIV: shift the next dividend bit into the remainder. When the
    // subtraction succeeds the true difference is below the divisor, so the
    // low WIDTH bits are exact.
    rem_sh  = {acc, shreg[WIDTH-1]};
    diff    = rem_sh[WIDTH-1:0] - operand;

    if (is_div) begin
      if (rem_sh >= {1'b0, operand}) begin
        acc_nxt   = diff;
        shreg_nxt = {shreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt   = rem_sh[WIDTH-1:0];
        shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt   = add_sum[WIDTH:1];
      shreg_nxt = {add_sum[0], shreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle signed MUL / DIV sequencer beside the ALU.
// Accepts one request on start_valid & start_ready, runs WIDTH radix-2
// iterations on operand magnitudes, fixes signs, and presents HI/LO.
// Ports:
//   clk, nRst    : rising-edge clock, asynchronous active-low reset
//   start_valid  : request present; start_ready high only when idle
//   ctrl         : ALU control code (ALU_DIV / ALU_MUL legal)
//   op_a, op_b   : signed operands, sampled at acceptance
//   busy         : high in every state except idle
//   done         : one-cycle completion pulse
//   hi, lo       : MUL product high/low, DIV remainder/quotient
//   div_zero     : DIV by zero (valid while done, held until next accept)
//   illegal      : unsupported ctrl (valid while done, held until next accept)
// Build option: define ALU_MULDIV_EARLY_EXIT_EN to let MUL leave the
// iteration loop once the remaining multiplier bits are all zero.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             illegal
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  muldiv_state_t state_q, state_d;

  logic             is_div_q;
  logic             neg_a_q;
  logic             neg_b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] operand_q;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] shreg_nxt;

  logic               accept;
  logic               ctrl_legal;
  logic               last_iter;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_signed;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div    (is_div_q),
    .acc       (acc_q),
    .shreg     (shreg_q),
    .operand   (operand_q),
    .acc_nxt   (acc_nxt),
    .shreg_nxt (shreg_nxt)
  );

  assign accept     = start_valid && (state_q == MD_IDLE);
  assign ctrl_legal = (ctrl == ALU_DIV) || (ctrl == ALU_MUL);

`ifdef ALU_MULDIV_EARLY_EXIT_EN
  // After this step, the low (cnt_q-1) bits of shreg_nxt still hold
  // unconsumed multiplier bits; once they are zero the loop can stop and
  // FIX realigns the product by the remaining count.
  logic [WIDTH-1:0] rem_mask;
  assign rem_mask  = ~({WIDTH{1'b1}} << (cnt_q - CW'(1)));
  assign last_iter = (cnt_q == CW'(1)) ||
                     (!is_div_q && ((shreg_nxt & rem_mask) == '0));
  assign prod_mag  = {acc_q, shreg_q} >> cnt_q;
`else
  assign last_iter = (cnt_q == CW'(1));
  assign prod_mag  = {acc_q, shreg_q};
`endif

  assign prod_signed = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;

  // State register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (start_valid) state_d = ctrl_legal ? MD_PREP : MD_DONE;
      MD_PREP: state_d = (is_div_q && (operand_q == '0)) ? MD_DONE : MD_RUN;
      MD_RUN:  if (last_iter) state_d = MD_FIX;
      MD_FIX:  state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    start_ready = (state_q == MD_IDLE);
    busy        = (state_q != MD_IDLE);
    done        = (state_q == MD_DONE);
  end

  // Datapath. At acceptance op_a parks in shreg_q and op_b in operand_q;
  // PREP converts them in place to magnitudes in the per-op arrangement.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      is_div_q  <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      shreg_q   <= '0;
      operand_q <= '0;
      hi        <= '0;
      lo        <= '0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (accept) begin
            is_div_q  <= (ctrl == ALU_DIV);
            shreg_q   <= op_a;
            operand_q <= op_b;
            div_zero  <= 1'b0;
            illegal   <= !ctrl_legal;
            if (!ctrl_legal) begin
              hi <= '0;
              lo <= '0;
            end
          end
        end
        MD_PREP: begin
          neg_a_q <= shreg_q[WIDTH-1];
          neg_b_q <= operand_q[WIDTH-1];
          acc_q   <= '0;
          cnt_q   <= CW'(WIDTH);
          if (is_div_q) begin
            operand_q <= mag(operand_q);
            shreg_q   <= mag(shreg_q);
            if (operand_q == '0) begin
              div_zero <= 1'b1;
              lo       <= '1;
              hi       <= shreg_q;
            end
          end else begin
            operand_q <= mag(shreg_q);
            shreg_q   <= mag(operand_q);
          end
        end
        MD_RUN: begin
          acc_q   <= acc_nxt;
          shreg_q <= shreg_nxt;
          cnt_q   <= cnt_q - CW'(1);
        end
        MD_FIX: begin
          if (is_div_q) begin
            lo <= (neg_a_q ^ neg_b_q) ? -shreg_q : shreg_q;
            hi <= neg_a_q ? -acc_q : acc_q;
          end else begin
            {hi, lo} <= prod_signed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
